// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: slews the PWM compare value toward a requested duty by a
// fixed STEP once per PWM period, holds for HOLD_PERIODS period ticks, then
// pulses done.
// Optional build macro PWM_DUTY_RAMP_BREATHE_EN adds a "breathe" input that
// self-issues alternating full-scale / zero targets while idle (triangle wave).
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a target; tgt_ready=1
// RAMP   | stepping duty toward target on each period_tick
// SETTLE | target reached; hold_cnt counts period ticks down to zero
module pwm_duty_ramp #(
    parameter int MAX_COUNT    = 27000,
    parameter int STEP         = 270,
    parameter int HOLD_PERIODS = 10,
    parameter int DW           = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          period_tick,
    input  logic [DW-1:0] tgt_duty,
    input  logic          tgt_valid,
`ifdef PWM_DUTY_RAMP_BREATHE_EN
    input  logic          breathe,
`endif
    output logic          tgt_ready,
    output logic [DW-1:0] duty,
    output logic          busy,
    output logic          done
);

    localparam int HW = (HOLD_PERIODS < 1) ? 1 : $clog2(HOLD_PERIODS + 1);

    localparam logic [DW-1:0] MAX_D     = DW'(MAX_COUNT);
    localparam logic [DW:0]   STEP_X    = (DW + 1)'(STEP);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_PERIODS);
`ifdef PWM_DUTY_RAMP_BREATHE_EN
    localparam logic [DW-1:0] HALF_D    = DW'(MAX_COUNT / 2);
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [DW-1:0]   target, target_n;
    logic [DW-1:0]   duty_n;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic            done_n;

    // One bit of headroom so duty+STEP never wraps before the compare.
    logic [DW:0]     duty_x, target_x, up_x, dn_x;

    // State, duty, latched target and hold timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            duty     <= '0;
            target   <= '0;
            hold_cnt <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            duty     <= duty_n;
            target   <= target_n;
            hold_cnt <= hold_n;
            done     <= done_n;
        end
    end

    // Next-state, slew arithmetic and hold-timer decrement.
    always_comb begin
        state_n  = state;
        duty_n   = duty;
        target_n = target;
        hold_n   = hold_cnt;
        done_n   = 1'b0;

        duty_x   = {1'b0, duty};
        target_x = {1'b0, target};
        up_x     = duty_x + STEP_X;
        dn_x     = duty_x - target_x;

        case (state)
            IDLE: begin
                if (tgt_valid) begin
                    target_n = (tgt_duty > MAX_D) ? MAX_D : tgt_duty;
                    state_n  = RAMP;
                end
`ifdef PWM_DUTY_RAMP_BREATHE_EN
                else if (breathe) begin
                    target_n = (duty < HALF_D) ? MAX_D : '0;
                    state_n  = RAMP;
                end
`endif
            end
            RAMP: begin
                if (period_tick) begin
                    if (duty < target) begin
                        duty_n = (up_x > target_x) ? target : up_x[DW-1:0];
                    end else if (duty > target) begin
                        // dn_x is only meaningful here because duty > target.
                        duty_n = (dn_x <= STEP_X) ? target : duty - STEP_X[DW-1:0];
                    end else begin
                        hold_n  = HOLD_INIT;
                        state_n = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (hold_cnt == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (period_tick) begin
                    hold_n = hold_cnt - HW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign tgt_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: inputs change on the falling edge,
// outputs are sampled on the falling edge after the rising edge that used them.
module tb_pwm_duty_ramp;

    localparam int MAX_COUNT    = 27000;
    localparam int STEP         = 270;
    localparam int HOLD_PERIODS = 10;
    localparam int DW           = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          period_tick = 1'b0;
    logic [DW-1:0] tgt_duty = '0;
    logic          tgt_valid = 1'b0;
    logic          breathe = 1'b0;
    logic          tgt_ready;
    logic [DW-1:0] duty;
    logic          busy;
    logic          done;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pwm_duty_ramp #(
        .MAX_COUNT   (MAX_COUNT),
        .STEP        (STEP),
        .HOLD_PERIODS(HOLD_PERIODS),
        .DW          (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .period_tick(period_tick),
        .tgt_duty   (tgt_duty),
        .tgt_valid  (tgt_valid),
`ifdef PWM_DUTY_RAMP_BREATHE_EN
        .breathe    (breathe),
`endif
        .tgt_ready  (tgt_ready),
        .duty       (duty),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // One-cycle period_tick; returns on the falling edge after it was used.
    task automatic pulse_tick();
        @(negedge clk) period_tick = 1'b1;
        @(negedge clk) period_tick = 1'b0;
    endtask

    task automatic accept(input int value);
        @(negedge clk) begin tgt_duty = DW'(value); tgt_valid = 1'b1; end
        @(negedge clk) tgt_valid = 1'b0;
        chk("accept_busy", busy, 1);
        chk("accept_ready", tgt_ready, 0);
    endtask

    // Equality tick, HOLD_PERIODS hold ticks, then the done pulse.
    task automatic finish_settle(input int exp_duty);
        pulse_tick();
        chk("settle_entry_busy", busy, 1);
        chk("settle_duty", duty, exp_duty);
        for (int i = 0; i < HOLD_PERIODS; i++) begin
            pulse_tick();
            if (i == HOLD_PERIODS - 1) chk("done_not_early", done, 0);
        end
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_ready", tgt_ready, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    int exp_up[5]   = '{270, 540, 810, 1080, 1350};
    int exp_down[5] = '{1080, 810, 540, 270, 100};
    int n_ticks;
    int max_seen;
    bit found;

    initial begin
        // Reset with a pending request that must be ignored.
        tgt_valid = 1'b1;
        tgt_duty  = DW'(500);
        repeat (3) @(negedge clk);
        chk("rst_duty", duty, 0);
        chk("rst_ready", tgt_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tgt_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);

        // Target equal to current duty still visits RAMP for one tick.
        accept(0);
        finish_settle(0);

        // Ramp up, with a tick coincident with acceptance (ignored).
        @(negedge clk) begin tgt_duty = DW'(1350); tgt_valid = 1'b1; period_tick = 1'b1; end
        @(negedge clk) begin tgt_valid = 1'b0; period_tick = 1'b0; end
        chk("coincident_tick_duty", duty, 0);
        chk("up_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            pulse_tick();
            chk($sformatf("up_%0d", i), duty, exp_up[i]);
        end
        @(negedge clk);
        @(negedge clk);
        chk("hold_no_tick", duty, 1350);
        finish_settle(1350);

        // Ramp down with a non-multiple final step.
        accept(100);
        for (int i = 0; i < 5; i++) begin
            pulse_tick();
            chk($sformatf("down_%0d", i), duty, exp_down[i]);
        end
        finish_settle(100);

        // Clamp: 30000 latches as 27000; 100 ticks from 100.
        accept(30000);
        n_ticks = 0;
        max_seen = 0;
        while (n_ticks < 120 && duty != MAX_COUNT) begin
            pulse_tick();
            n_ticks++;
            if (duty > max_seen) max_seen = duty;
        end
        chk("clamp_ticks", n_ticks, 100);
        chk("clamp_max", max_seen, 27000);
        finish_settle(27000);

        // Back-pressure: request held during the whole busy window.
        accept(26730);
        pulse_tick();
        chk("bp_step", duty, 26730);
        @(negedge clk) begin tgt_duty = DW'(500); tgt_valid = 1'b1; end
        @(negedge clk);
        chk("bp_not_ready", tgt_ready, 0);
        finish_settle(26730);
        chk("bp_accepted", busy, 1);
        tgt_valid = 1'b0;

        // Reset mid-ramp at duty 540 (26730 -> 500 passes through 540).
        found = 1'b0;
        for (int i = 0; i < 120 && !found; i++) begin
            pulse_tick();
            if (duty == 540) found = 1'b1;
        end
        chk("reach_540", found, 1);
        chk("mid_busy", busy, 1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("mid_rst_duty", duty, 0);
        chk("mid_rst_ready", tgt_ready, 1);
        chk("mid_rst_done", done, 0);
        repeat (3) @(negedge clk);
        chk("no_done_after_rst", done, 0);
        chk("idle_after_rst", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
